rom_bus_arbiter: RTL and testbench

- Shares the single SRAM0 ("ROM") port between the SNES bus and the MCU.
- SNES inputs are the mapped address and write-enable already produced by address decode (ROM_ADDR, IS_WRITABLE-gated).
- SNES always has priority. MCU accesses are slotted into idle gaps and sequenced with fixed-length SRAM cycles.
- Sits between the address decoder/SNES bus glue and the SRAM0 pins.

---
 rtl/rom_bus_arbiter.sv | 221 ++++++++++++++++++++++
 tb/tb_rom_bus_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/rom_bus_arbiter.sv
// rtl/rom_bus_arbiter.sv - SRAM0 port arbiter: SNES priority, MCU in idle gaps, fixed-length accesses.
// Optional third requester enabled by defining ROM_BUS_ARBITER_DMA_EN.
module rom_bus_arbiter #(
  parameter int ACCESS_CYCLES = 4,
  parameter int MCU_HOLDOFF   = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        SNES_REQ,
  input  logic        SNES_WE,
  input  logic [23:0] SNES_ADDR_IN,
  input  logic [7:0]  SNES_WDATA,
  output logic [7:0]  SNES_RDATA,
  output logic        SNES_RDY,
  input  logic        MCU_RRQ,
  input  logic        MCU_WRQ,
  input  logic [23:0] MCU_ADDR,
  input  logic [7:0]  MCU_WDATA,
  output logic [7:0]  MCU_RDATA,
  output logic        MCU_RDY,
`ifdef ROM_BUS_ARBITER_DMA_EN
  input  logic        DMA_REQ,
  input  logic        DMA_WE,
  input  logic [23:0] DMA_ADDR,
  input  logic [7:0]  DMA_WDATA,
  output logic [7:0]  DMA_RDATA,
  output logic        DMA_RDY,
`endif
  output logic [23:0] ROM_ADDR_OUT,
  output logic [7:0]  ROM_DOUT,
  input  logic [7:0]  ROM_DIN,
  output logic        ROM_DOUT_OE,
  output logic        ROM_CE_N,
  output logic        ROM_OE_N,
  output logic        ROM_WE_N
);

  localparam int HW = $clog2(MCU_HOLDOFF + 2);

`ifdef ROM_BUS_ARBITER_DMA_EN
  typedef enum logic [1:0] {IDLE, SNES_ACC, MCU_ACC, DMA_ACC} state_t;
`else
  typedef enum logic [1:0] {IDLE, SNES_ACC, MCU_ACC} state_t;
`endif

  state_t state, state_next;
  logic [3:0]    cnt;
  logic [HW-1:0] holdoff;
  logic          acc_we;
  logic          in_acc, last;
  logic          snes_go, mcu_go;

  logic          snes_pend, snes_we_q;
  logic [23:0]   snes_addr_q;
  logic [7:0]    snes_wdata_q;
  logic          mcu_pend, mcu_we_q;
  logic [23:0]   mcu_addr_q;
  logic [7:0]    mcu_wdata_q;

`ifdef ROM_BUS_ARBITER_DMA_EN
  logic          dma_go, dma_pend, dma_we_q, last_dma;
  logic [23:0]   dma_addr_q;
  logic [7:0]    dma_wdata_q;
`endif

  assign in_acc = (state != IDLE);
  assign last   = (cnt == 4'(ACCESS_CYCLES - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    snes_go    = 1'b0;
    mcu_go     = 1'b0;
`ifdef ROM_BUS_ARBITER_DMA_EN
    dma_go     = 1'b0;
`endif
    case (state)
      IDLE: begin
        // SNES_REQ on this cycle is granted directly (zero-wait bypass).
        if (snes_pend || SNES_REQ) begin
          snes_go    = 1'b1;
          state_next = SNES_ACC;
        end else if (holdoff == '0) begin
`ifdef ROM_BUS_ARBITER_DMA_EN
          if (mcu_pend && (!dma_pend || last_dma)) begin
            mcu_go     = 1'b1;
            state_next = MCU_ACC;
          end else if (dma_pend) begin
            dma_go     = 1'b1;
            state_next = DMA_ACC;
          end
`else
          if (mcu_pend) begin
            mcu_go     = 1'b1;
            state_next = MCU_ACC;
          end
`endif
        end
      end
      default: if (last) state_next = IDLE;
    endcase
  end

  assign ROM_CE_N    = !in_acc;
  assign ROM_OE_N    = !(in_acc && !acc_we);
  assign ROM_DOUT_OE = in_acc && acc_we;
  // One cycle of setup and one of hold around the write pulse.
  assign ROM_WE_N    = !(in_acc && acc_we && (cnt >= 4'd1) && (cnt <= 4'(ACCESS_CYCLES - 2)));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt          <= '0;
      holdoff      <= '0;
      acc_we       <= 1'b0;
      snes_pend    <= 1'b0;
      snes_we_q    <= 1'b0;
      snes_addr_q  <= '0;
      snes_wdata_q <= '0;
      mcu_pend     <= 1'b0;
      mcu_we_q     <= 1'b0;
      mcu_addr_q   <= '0;
      mcu_wdata_q  <= '0;
      ROM_ADDR_OUT <= '0;
      ROM_DOUT     <= '0;
      SNES_RDATA   <= '0;
      SNES_RDY     <= 1'b0;
      MCU_RDATA    <= '0;
      MCU_RDY      <= 1'b0;
`ifdef ROM_BUS_ARBITER_DMA_EN
      dma_pend     <= 1'b0;
      dma_we_q     <= 1'b0;
      dma_addr_q   <= '0;
      dma_wdata_q  <= '0;
      last_dma     <= 1'b1;
      DMA_RDATA    <= '0;
      DMA_RDY      <= 1'b0;
`endif
    end else begin
      SNES_RDY <= 1'b0;
      MCU_RDY  <= 1'b0;

      if (in_acc && !last) cnt <= cnt + 4'd1;
      else                 cnt <= '0;

      if (state == SNES_ACC && last)        holdoff <= HW'(MCU_HOLDOFF);
      else if (!in_acc && holdoff != '0)    holdoff <= holdoff - HW'(1);

      // A bypassed request never lands in the pending slot.
      if (SNES_REQ && !(snes_go && !snes_pend)) begin
        snes_pend    <= 1'b1;
        snes_we_q    <= SNES_WE;
        snes_addr_q  <= SNES_ADDR_IN;
        snes_wdata_q <= SNES_WDATA;
      end else if (snes_go) begin
        snes_pend <= 1'b0;
      end

      if (MCU_RRQ || MCU_WRQ) begin
        mcu_pend    <= 1'b1;
        mcu_we_q    <= MCU_WRQ;
        mcu_addr_q  <= MCU_ADDR;
        mcu_wdata_q <= MCU_WDATA;
      end else if (mcu_go) begin
        mcu_pend <= 1'b0;
      end

      if (snes_go) begin
        acc_we       <= snes_pend ? snes_we_q    : SNES_WE;
        ROM_ADDR_OUT <= snes_pend ? snes_addr_q  : SNES_ADDR_IN;
        ROM_DOUT     <= snes_pend ? snes_wdata_q : SNES_WDATA;
      end else if (mcu_go) begin
        acc_we       <= mcu_we_q;
        ROM_ADDR_OUT <= mcu_addr_q;
        ROM_DOUT     <= mcu_wdata_q;
      end

`ifdef ROM_BUS_ARBITER_DMA_EN
      if (DMA_REQ) begin
        dma_pend    <= 1'b1;
        dma_we_q    <= DMA_WE;
        dma_addr_q  <= DMA_ADDR;
        dma_wdata_q <= DMA_WDATA;
      end else if (dma_go) begin
        dma_pend <= 1'b0;
      end
      if (mcu_go) last_dma <= 1'b0;
      if (dma_go) begin
        last_dma     <= 1'b1;
        acc_we       <= dma_we_q;
        ROM_ADDR_OUT <= dma_addr_q;
        ROM_DOUT     <= dma_wdata_q;
      end
`endif

      if (in_acc && last) begin
        case (state)
          SNES_ACC: begin
            SNES_RDY <= 1'b1;
            if (!acc_we) SNES_RDATA <= ROM_DIN;
          end
          MCU_ACC: begin
            MCU_RDY <= 1'b1;
            if (!acc_we) MCU_RDATA <= ROM_DIN;
          end
`ifdef ROM_BUS_ARBITER_DMA_EN
          DMA_ACC: begin
            DMA_RDY <= 1'b1;
            if (!acc_we) DMA_RDATA <= ROM_DIN;
          end
`endif
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rom_bus_arbiter.sv
// tb/tb_rom_bus_arbiter.sv - cycle-table and directed-sequence bench for rom_bus_arbiter.
module tb_rom_bus_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        SNES_REQ, SNES_WE;
  logic [23:0] SNES_ADDR_IN;
  logic [7:0]  SNES_WDATA, SNES_RDATA;
  logic        SNES_RDY;
  logic        MCU_RRQ, MCU_WRQ;
  logic [23:0] MCU_ADDR;
  logic [7:0]  MCU_WDATA, MCU_RDATA;
  logic        MCU_RDY;
  logic [23:0] ROM_ADDR_OUT;
  logic [7:0]  ROM_DOUT, ROM_DIN;
  logic        ROM_DOUT_OE, ROM_CE_N, ROM_OE_N, ROM_WE_N;
`ifdef ROM_BUS_ARBITER_DMA_EN
  logic        DMA_RDY;
  logic [7:0]  DMA_RDATA;
`endif

  rom_bus_arbiter dut (
    .CLK(CLK), .RST(RST),
    .SNES_REQ(SNES_REQ), .SNES_WE(SNES_WE), .SNES_ADDR_IN(SNES_ADDR_IN),
    .SNES_WDATA(SNES_WDATA), .SNES_RDATA(SNES_RDATA), .SNES_RDY(SNES_RDY),
    .MCU_RRQ(MCU_RRQ), .MCU_WRQ(MCU_WRQ), .MCU_ADDR(MCU_ADDR),
    .MCU_WDATA(MCU_WDATA), .MCU_RDATA(MCU_RDATA), .MCU_RDY(MCU_RDY),
`ifdef ROM_BUS_ARBITER_DMA_EN
    .DMA_REQ(1'b0), .DMA_WE(1'b0), .DMA_ADDR(24'h0), .DMA_WDATA(8'h0),
    .DMA_RDATA(DMA_RDATA), .DMA_RDY(DMA_RDY),
`endif
    .ROM_ADDR_OUT(ROM_ADDR_OUT), .ROM_DOUT(ROM_DOUT), .ROM_DIN(ROM_DIN),
    .ROM_DOUT_OE(ROM_DOUT_OE), .ROM_CE_N(ROM_CE_N), .ROM_OE_N(ROM_OE_N),
    .ROM_WE_N(ROM_WE_N)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Inputs for one cycle, expected {CE_N,OE_N,WE_N,DOUT_OE,SNES_RDY,MCU_RDY} and address after the edge.
  typedef struct {
    logic        sreq;
    logic        mrrq;
    logic        mwrq;
    logic [5:0]  exp;
    logic [23:0] eaddr;
  } vec_t;

  vec_t tv[24];

  task automatic wait_rdy(input bit snes, input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge CLK);
      if ((snes && SNES_RDY) || (!snes && MCU_RDY)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit ok, we_seen;
    logic [7:0] dout_at_we, exp_mrdata;
    int rdy_cnt;

    RST = 1'b1; SNES_REQ = 0; SNES_WE = 0; SNES_ADDR_IN = 24'h123456; SNES_WDATA = 8'h77;
    MCU_RRQ = 0; MCU_WRQ = 0; MCU_ADDR = 24'hE00010; MCU_WDATA = 8'h3C; ROM_DIN = 8'hA5;

    tv[0]  = '{1'b1, 1'b0, 1'b0, 6'b001000, 24'h123456};
    tv[1]  = '{1'b0, 1'b0, 1'b0, 6'b001000, 24'h123456};
    tv[2]  = '{1'b0, 1'b0, 1'b0, 6'b001000, 24'h123456};
    tv[3]  = '{1'b0, 1'b0, 1'b0, 6'b001000, 24'h123456};
    tv[4]  = '{1'b0, 1'b0, 1'b0, 6'b111010, 24'h123456};
    tv[5]  = '{1'b0, 1'b0, 1'b0, 6'b111000, 24'h123456};
    tv[6]  = '{1'b0, 1'b0, 1'b0, 6'b111000, 24'h123456};
    tv[7]  = '{1'b0, 1'b0, 1'b1, 6'b111000, 24'h123456};
    tv[8]  = '{1'b0, 1'b0, 1'b0, 6'b011100, 24'hE00010};
    tv[9]  = '{1'b0, 1'b0, 1'b0, 6'b010100, 24'hE00010};
    tv[10] = '{1'b0, 1'b0, 1'b0, 6'b010100, 24'hE00010};
    tv[11] = '{1'b0, 1'b0, 1'b0, 6'b011100, 24'hE00010};
    tv[12] = '{1'b0, 1'b0, 1'b0, 6'b111001, 24'hE00010};
    tv[13] = '{1'b0, 1'b1, 1'b0, 6'b111000, 24'hE00010};
    tv[14] = '{1'b0, 1'b0, 1'b0, 6'b001000, 24'hE00010};
    tv[15] = '{1'b1, 1'b0, 1'b0, 6'b001000, 24'hE00010};
    tv[16] = '{1'b0, 1'b0, 1'b0, 6'b001000, 24'hE00010};
    tv[17] = '{1'b0, 1'b0, 1'b0, 6'b001000, 24'hE00010};
    tv[18] = '{1'b0, 1'b0, 1'b0, 6'b111001, 24'hE00010};
    tv[19] = '{1'b0, 1'b0, 1'b0, 6'b001000, 24'h123456};
    tv[20] = '{1'b0, 1'b0, 1'b0, 6'b001000, 24'h123456};
    tv[21] = '{1'b0, 1'b0, 1'b0, 6'b001000, 24'h123456};
    tv[22] = '{1'b0, 1'b0, 1'b0, 6'b001000, 24'h123456};
    tv[23] = '{1'b0, 1'b0, 1'b0, 6'b111010, 24'h123456};

    @(negedge CLK); @(negedge CLK);
    chk("reset_strobes", {28'h0, ROM_CE_N, ROM_OE_N, ROM_WE_N, ROM_DOUT_OE}, 32'hE);
    chk("reset_addr", ROM_ADDR_OUT, 32'h0);
    chk("reset_dout", ROM_DOUT, 32'h0);
    chk("reset_rdata", {SNES_RDATA, MCU_RDATA}, 32'h0);
    chk("reset_rdy", {SNES_RDY, MCU_RDY}, 32'h0);
    RST = 1'b0;

    for (int i = 0; i < 24; i++) begin
      SNES_REQ = tv[i].sreq; MCU_RRQ = tv[i].mrrq; MCU_WRQ = tv[i].mwrq;
      @(negedge CLK);
      chk($sformatf("vec%0d_ctl", i),
          {26'h0, ROM_CE_N, ROM_OE_N, ROM_WE_N, ROM_DOUT_OE, SNES_RDY, MCU_RDY}, {26'h0, tv[i].exp});
      chk($sformatf("vec%0d_addr", i), ROM_ADDR_OUT, {8'h0, tv[i].eaddr});
      if (tv[i].exp[2]) chk($sformatf("vec%0d_dout", i), ROM_DOUT, 32'h3C);
      if (tv[i].exp[1]) chk($sformatf("vec%0d_snes_rdata", i), SNES_RDATA, 32'hA5);
      if (tv[i].exp[0] && i == 18) chk("vec18_mcu_rdata", MCU_RDATA, 32'hA5);
    end
    SNES_REQ = 0; MCU_RRQ = 0; MCU_WRQ = 0;

    // MCU read queued right after a SNES access must wait out the holdoff.
    MCU_RRQ = 1; MCU_ADDR = 24'h000321; ROM_DIN = 8'hC3;
    @(negedge CLK); MCU_RRQ = 0;
    chk("holdoff_idle1", ROM_CE_N, 1);
    @(negedge CLK);
    chk("holdoff_idle2", ROM_CE_N, 1);
    @(negedge CLK);
    chk("holdoff_start", {ROM_CE_N, ROM_ADDR_OUT}, {1'b0, 24'h000321});
    wait_rdy(1'b0, 10, ok);
    chk("holdoff_mcu_rdy", ok, 1);
    chk("holdoff_mcu_rdata", MCU_RDATA, 32'hC3);

    // SNES request arriving during holdoff beats the pending MCU read.
    SNES_REQ = 1; SNES_ADDR_IN = 24'h0ABCDE;
    @(negedge CLK); SNES_REQ = 0;
    wait_rdy(1'b1, 10, ok);
    chk("hold2_snes_rdy", ok, 1);
    MCU_RRQ = 1; MCU_ADDR = 24'h000555;
    @(negedge CLK); MCU_RRQ = 0;
    SNES_REQ = 1; SNES_ADDR_IN = 24'h0BBBBB;
    @(negedge CLK); SNES_REQ = 0;
    chk("hold2_snes_first", {ROM_CE_N, ROM_ADDR_OUT}, {1'b0, 24'h0BBBBB});
    wait_rdy(1'b1, 10, ok);
    chk("hold2_snes_rdy2", ok, 1);
    wait_rdy(1'b0, 20, ok);
    chk("hold2_mcu_rdy", ok, 1);
    chk("hold2_mcu_addr", ROM_ADDR_OUT, 32'h000555);
    exp_mrdata = 8'hC3;

    // Simultaneous read and write requests: the write wins.
    MCU_RRQ = 1; MCU_WRQ = 1; MCU_WDATA = 8'h5A; MCU_ADDR = 24'h000777; ROM_DIN = 8'h11;
    @(negedge CLK); MCU_RRQ = 0; MCU_WRQ = 0;
    we_seen = 0; dout_at_we = 8'h00; ok = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge CLK);
      if (!ROM_WE_N) begin we_seen = 1; dout_at_we = ROM_DOUT; end
      if (MCU_RDY) begin ok = 1; break; end
    end
    chk("both_rdy", ok, 1);
    chk("both_we_seen", we_seen, 1);
    chk("both_dout", dout_at_we, 32'h5A);
    chk("both_rdata_kept", MCU_RDATA, {24'h0, exp_mrdata});

    // Reset during access cycle 2 of a write.
    MCU_WRQ = 1; MCU_WDATA = 8'h99;
    @(negedge CLK); MCU_WRQ = 0;
    @(negedge CLK); @(negedge CLK); @(negedge CLK);
    chk("rst_pre_we", ROM_WE_N, 0);
    #2 RST = 1'b1;
    #1;
    chk("rst_async_strobes", {ROM_WE_N, ROM_CE_N, ROM_DOUT_OE}, 32'h6);
    rdy_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      if (MCU_RDY) rdy_cnt++;
    end
    RST = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge CLK);
      if (MCU_RDY) rdy_cnt++;
    end
    chk("rst_no_mcu_rdy", rdy_cnt, 0);
    chk("rst_mcu_rdata", MCU_RDATA, 32'h0);

    SNES_REQ = 1; SNES_ADDR_IN = 24'h00F00D; ROM_DIN = 8'h6E;
    @(negedge CLK); SNES_REQ = 0;
    chk("post_rst_start", {ROM_CE_N, ROM_OE_N, ROM_ADDR_OUT}, {2'b00, 24'h00F00D});
    wait_rdy(1'b1, 10, ok);
    chk("post_rst_rdy", ok, 1);
    chk("post_rst_rdata", SNES_RDATA, 32'h6E);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
